// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the reg_file_sb register file and its scoreboard.
package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_RD_DEF = 2;

  // Low bit of port `port` inside a flattened bus of `width`-bit slices
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of reg_file_sb; master = controller side, slave = register file.
interface reg_file_sb_if import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic [DATA_W-1:0]        WRITEDATA;
  logic [ADDR_W-1:0]        WRITEREG;
  logic                     WRITEENABLE;
  logic [NUM_RD*ADDR_W-1:0] READREG;
  logic [NUM_RD-1:0]        READEN;
  logic [NUM_RD*DATA_W-1:0] REGOUT;
  logic                     RESERVE;
  logic [ADDR_W-1:0]        RESERVEREG;
  logic [NUM_RD-1:0]        BUSY;
  logic                     STALL;
  logic [ADDR_W:0]          PEND_COUNT;

  modport master (
    output WRITEDATA, WRITEREG, WRITEENABLE, READREG, READEN, RESERVE, RESERVEREG,
    input  REGOUT, BUSY, STALL, PEND_COUNT
  );

  modport slave (
    input  WRITEDATA, WRITEREG, WRITEENABLE, READREG, READEN, RESERVE, RESERVEREG,
    output REGOUT, BUSY, STALL, PEND_COUNT
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-load scoreboard: per-register pend bits, their population count and per-port lookup.
module reg_scoreboard import reg_file_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_idx,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_idx,
  input  logic [NUM_RD*ADDR_W-1:0] read_idx,
  output logic [NUM_RD-1:0]        busy,
  output logic [ADDR_W:0]          pend_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0] pend;
  logic             set_eff;
  logic             clr_eff;

  // A set on the same index as a clear wins, so that clear is not effective
  always_comb begin
    set_eff = set_en & ~pend[set_idx];
    clr_eff = clr_en & pend[clr_idx] & ~(set_en & (set_idx == clr_idx));
  end

  // Pend vector and its running count
  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      pend_count <= '0;
    end else begin
      if (clr_en) pend[clr_idx] <= 1'b0;
      if (set_en) pend[set_idx] <= 1'b1;
      case ({set_eff, clr_eff})
        2'b10:   pend_count <= pend_count + ONE;
        2'b01:   pend_count <= pend_count - ONE;
        default: pend_count <= pend_count;
      endcase
    end
  end

  // Per-port pending lookup
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      busy[i] = pend[read_idx[slice_lo(i, ADDR_W) +: ADDR_W]];
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with pending-load scoreboard; define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [NUM_RD-1:0]        busy_stored;
  logic [NUM_RD-1:0]        busy;
  logic [NUM_RD*DATA_W-1:0] regout;
  logic [ADDR_W-1:0]        rd_idx;

  reg_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
    .clk        (CLK),
    .reset      (RESET),
    .set_en     (bus.RESERVE),
    .set_idx    (bus.RESERVEREG),
    .clr_en     (bus.WRITEENABLE),
    .clr_idx    (bus.WRITEREG),
    .read_idx   (bus.READREG),
    .busy       (busy_stored),
    .pend_count (bus.PEND_COUNT)
  );

  // Register array write port
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else if (bus.WRITEENABLE) begin
      regs[bus.WRITEREG] <= bus.WRITEDATA;
    end else begin
      regs <= regs;
    end
  end

  // Read muxes; the forwarding path still reports busy when the same index is re-reserved
  always_comb begin
    regout = '0;
    busy   = '0;
    rd_idx = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_idx = bus.READREG[slice_lo(i, ADDR_W) +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
      if (bus.WRITEENABLE && (bus.WRITEREG == rd_idx)) begin
        regout[slice_lo(i, DATA_W) +: DATA_W] = bus.WRITEDATA;
        busy[i] = bus.RESERVE && (bus.RESERVEREG == bus.WRITEREG);
      end else begin
        regout[slice_lo(i, DATA_W) +: DATA_W] = regs[rd_idx];
        busy[i] = busy_stored[i];
      end
`else
      regout[slice_lo(i, DATA_W) +: DATA_W] = regs[rd_idx];
      busy[i] = busy_stored[i];
`endif
    end
  end

  assign bus.REGOUT = regout;
  assign bus.BUSY   = busy;
  assign bus.STALL  = |(busy & bus.READEN);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: vector table, corner sequences, random run vs. model.
module tb_reg_file_sb;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK;
  logic RESET;
  int   n_cmp  = 0;
  int   n_fail = 0;

  reg_file_sb_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) ifa ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) ifb ();

  reg_file_sb #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model of the 8-bit, 2-port instance
  logic [7:0] mem_m  [8];
  bit         pend_m [8];

  typedef struct packed {
    logic       we;
    logic [2:0] wreg;
    logic [7:0] wdata;
    logic       res;
    logic [2:0] rres;
    logic [2:0] rr0;
    logic [2:0] rr1;
    logic [1:0] en;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [1:0] xbusy;
    logic       xstall;
    logic [3:0] xcnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (RESET) begin
      for (int k = 0; k < 8; k++) begin
        mem_m[k]  = 8'd0;
        pend_m[k] = 1'b0;
      end
    end else begin
      if (ifa.WRITEENABLE) begin
        mem_m[ifa.WRITEREG]  = ifa.WRITEDATA;
        pend_m[ifa.WRITEREG] = 1'b0;
      end
      if (ifa.RESERVE) pend_m[ifa.RESERVEREG] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic apply_a(input logic we, input logic [2:0] wreg, input logic [7:0] wdata,
                         input logic res, input logic [2:0] rres,
                         input logic [2:0] rr0, input logic [2:0] rr1, input logic [1:0] en);
    ifa.WRITEENABLE = we;
    ifa.WRITEREG    = wreg;
    ifa.WRITEDATA   = wdata;
    ifa.RESERVE     = res;
    ifa.RESERVEREG  = rres;
    ifa.READREG     = {rr1, rr0};
    ifa.READEN      = en;
  endtask

  function automatic logic [7:0] exp_out(input int p);
    logic [2:0] idx;
    idx = ifa.READREG[p*3 +: 3];
    if (BYP && ifa.WRITEENABLE && (ifa.WRITEREG == idx)) return ifa.WRITEDATA;
    return mem_m[idx];
  endfunction

  function automatic logic exp_busy(input int p);
    logic [2:0] idx;
    idx = ifa.READREG[p*3 +: 3];
    if (BYP && ifa.WRITEENABLE && (ifa.WRITEREG == idx))
      return ifa.RESERVE && (ifa.RESERVEREG == ifa.WRITEREG);
    return pend_m[idx];
  endfunction

  function automatic int pend_total();
    int c;
    c = 0;
    for (int k = 0; k < 8; k++) c += int'(pend_m[k]);
    return c;
  endfunction

  task automatic check_model();
    logic [1:0] eb;
    eb = {exp_busy(1), exp_busy(0)};
    chk("rand_regout0", ifa.REGOUT[7:0],  exp_out(0));
    chk("rand_regout1", ifa.REGOUT[15:8], exp_out(1));
    chk("rand_busy",    ifa.BUSY,         eb);
    chk("rand_stall",   ifa.STALL,        |(eb & ifa.READEN));
    chk("rand_pendcnt", ifa.PEND_COUNT,   pend_total());
  endtask

  initial begin
    logic [15:0] slice_b;

    RESET = 1'b1;
    apply_a(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd4, 2'b00);
    ifb.WRITEENABLE = 1'b0; ifb.WRITEREG = 3'd0; ifb.WRITEDATA = 16'd0;
    ifb.RESERVE = 1'b0; ifb.RESERVEREG = 3'd0; ifb.READREG = 12'd0; ifb.READEN = 4'd0;
    tick();
    tick();
    RESET = 1'b0;

    //           we    wreg  wdata   res   rres  rr0   rr1   en     x0      x1      xbusy  xst   xcnt
    tbl[0]  = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd0, 3'd4, 2'b00, 8'd0,  8'd0,  2'b00, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 3'd2, 8'd95, 1'b0, 3'd0, 3'd3, 3'd5, 2'b00, 8'd0,  8'd0,  2'b00, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd2, 3'd2, 2'b00, 8'd95, 8'd95, 2'b00, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd1, 3'd2, 3'd0, 2'b00, 8'd95, 8'd0,  2'b00, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd1, 3'd2, 2'b01, 8'd0,  8'd95, 2'b01, 1'b1, 4'd1};
    tbl[5]  = '{1'b1, 3'd1, 8'd28, 1'b0, 3'd0, 3'd2, 3'd3, 2'b01, 8'd95, 8'd0,  2'b00, 1'b0, 4'd1};
    tbl[6]  = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd1, 3'd2, 2'b01, 8'd28, 8'd95, 2'b00, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 3'd4, 8'd6,  1'b1, 3'd4, 3'd0, 3'd1, 2'b00, 8'd0,  8'd28, 2'b00, 1'b0, 4'd0};
    tbl[8]  = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd4, 3'd4, 2'b11, 8'd6,  8'd6,  2'b11, 1'b1, 4'd1};
    tbl[9]  = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd4, 3'd4, 3'd4, 2'b00, 8'd6,  8'd6,  2'b11, 1'b0, 4'd1};
    tbl[10] = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd4, 3'd4, 2'b10, 8'd6,  8'd6,  2'b11, 1'b1, 4'd1};

    for (int r = 0; r < 11; r++) begin
      apply_a(tbl[r].we, tbl[r].wreg, tbl[r].wdata, tbl[r].res, tbl[r].rres,
              tbl[r].rr0, tbl[r].rr1, tbl[r].en);
      @(negedge CLK);
      chk($sformatf("tbl%0d_regout0", r), ifa.REGOUT[7:0],  tbl[r].x0);
      chk($sformatf("tbl%0d_regout1", r), ifa.REGOUT[15:8], tbl[r].x1);
      chk($sformatf("tbl%0d_busy", r),    ifa.BUSY,         tbl[r].xbusy);
      chk($sformatf("tbl%0d_stall", r),   ifa.STALL,        tbl[r].xstall);
      chk($sformatf("tbl%0d_pendcnt", r), ifa.PEND_COUNT,   tbl[r].xcnt);
      tick();
    end

    // Same-cycle write/read of a non-pending register
    apply_a(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 3'd3, 3'd3, 2'b00);
    @(negedge CLK);
    chk("fwd_data_same_cycle", ifa.REGOUT[7:0], BYP ? 8'h5A : 8'h00);
    chk("fwd_busy_same_cycle", ifa.BUSY, 2'b00);
    tick();
    apply_a(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd3, 3'd3, 2'b00);
    @(negedge CLK);
    chk("wr_data_next_cycle", ifa.REGOUT[7:0], 8'h5A);
    tick();

    // Writeback into the pending r4 while port 0 reads it
    apply_a(1'b1, 3'd4, 8'h4D, 1'b0, 3'd0, 3'd4, 3'd0, 2'b01);
    @(negedge CLK);
    chk("fwd_clear_data", ifa.REGOUT[7:0], BYP ? 8'h4D : 8'h06);
    chk("fwd_clear_busy", ifa.BUSY[0], BYP ? 1'b0 : 1'b1);
    tick();
    apply_a(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd4, 3'd0, 2'b01);
    @(negedge CLK);
    chk("clear_busy_after", ifa.BUSY[0], 1'b0);
    chk("clear_cnt_after", ifa.PEND_COUNT, 4'd0);
    tick();

    // Write and reserve r5 together while reading it
    apply_a(1'b1, 3'd5, 8'd11, 1'b1, 3'd5, 3'd5, 3'd0, 2'b01);
    @(negedge CLK);
    chk("fwd_rsv_busy", ifa.BUSY[0], BYP ? 1'b1 : 1'b0);
    chk("fwd_rsv_stall", ifa.STALL, BYP ? 1'b1 : 1'b0);
    tick();
    apply_a(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd5, 3'd0, 2'b01);
    @(negedge CLK);
    chk("rsv_wr_data", ifa.REGOUT[7:0], 8'd11);
    chk("rsv_wr_busy", ifa.BUSY[0], 1'b1);
    chk("rsv_wr_cnt", ifa.PEND_COUNT, 4'd1);
    tick();

    // Reserve every register on successive edges; count saturates at DEPTH
    for (int k = 0; k < 8; k++) begin
      apply_a(1'b0, 3'd0, 8'd0, 1'b1, 3'(k), 3'(k), 3'(k), 2'b00);
      tick();
      if (k == 5) chk("rereserve_cnt", ifa.PEND_COUNT, 4'd6);
    end
    apply_a(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd7, 3'd0, 2'b11);
    @(negedge CLK);
    chk("full_cnt", ifa.PEND_COUNT, 4'd8);
    chk("full_busy", ifa.BUSY, 2'b11);
    tick();

    // Reset wins over a concurrent write and reserve
    RESET = 1'b1;
    apply_a(1'b1, 3'd7, 8'd50, 1'b1, 3'd7, 3'd7, 3'd0, 2'b11);
    tick();
    RESET = 1'b0;
    apply_a(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd7, 3'd0, 2'b11);
    @(negedge CLK);
    chk("rst_r7", ifa.REGOUT[7:0], 8'd0);
    chk("rst_cnt", ifa.PEND_COUNT, 4'd0);
    chk("rst_busy", ifa.BUSY, 2'b00);
    chk("rst_stall", ifa.STALL, 1'b0);
    tick();

    // Randomised traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      RESET = ($urandom_range(63) == 0);
      apply_a(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom),
              ($urandom_range(2) == 0), 3'($urandom_range(7)),
              3'($urandom_range(7)), 3'($urandom_range(7)), 2'($urandom_range(3)));
      @(negedge CLK);
      check_model();
      tick();
    end
    RESET = 1'b0;
    apply_a(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00);

    // Wide, four-port instance
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ifb.WRITEENABLE = 1'b1; ifb.WRITEREG = 3'd7; ifb.WRITEDATA = 16'hBEEF;
    tick();
    ifb.WRITEENABLE = 1'b0;
    ifb.READREG = {3'd7, 3'd7, 3'd7, 3'd7};
    @(negedge CLK);
    for (int p = 0; p < 4; p++) begin
      slice_b = ifb.REGOUT[p*16 +: 16];
      chk($sformatf("wide_port%0d", p), slice_b, 16'hBEEF);
    end
    tick();
    ifb.RESERVE = 1'b1; ifb.RESERVEREG = 3'd2;
    tick();
    ifb.RESERVE = 1'b0;
    ifb.READREG = {3'd2, 3'd7, 3'd2, 3'd7};
    ifb.READEN  = 4'b0010;
    @(negedge CLK);
    chk("wide_busy", ifb.BUSY, 4'b1010);
    chk("wide_stall_hit", ifb.STALL, 1'b1);
    chk("wide_cnt", ifb.PEND_COUNT, 4'd1);
    ifb.READEN = 4'b0101;
    #1;
    chk("wide_stall_miss", ifb.STALL, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated per-register pending scoreboard. It is the next-generation register file for the CPU datapath, sitting between decode (read ports, reservations) and writeback (write port). It generalises width, depth and read-port count. It also tracks registers awaiting a long-latency load from the memory hierarchy, so the controller can stall on read-after-load hazards.

## Interface
- DATA_W, default 8: register width in bits
- ADDR_W, default 3: address width; DEPTH = 2**ADDR_W registers
- NUM_RD, default 2: number of read ports, 1..4
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- WRITEDATA  in  DATA_W  writeback data
- WRITEREG  in  ADDR_W  writeback register index
- WRITEENABLE  in  1  commit WRITEDATA to WRITEREG at next edge
- READREG  in  NUM_RD*ADDR_W  read indices; port i at bits [i*ADDR_W +: ADDR_W]
- READEN  in  NUM_RD  port i is consuming its operand this cycle
- REGOUT  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- RESERVE  in  1  mark RESERVEREG pending (load issued)
- RESERVEREG  in  ADDR_W  register to reserve
- BUSY  out  NUM_RD  port i reads a pending register
- STALL  out  1  OR over i of (BUSY[i] & READEN[i])
- PEND_COUNT  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: DEPTH x DATA_W array plus a DEPTH-bit pend vector.
- Write: at a rising edge with WRITEENABLE=1 and RESET=0, regArr[WRITEREG] <= WRITEDATA and pend[WRITEREG] <= 0.
- Reserve: at a rising edge with RESERVE=1 and RESET=0, pend[RESERVEREG] <= 1.
- Reserve and write to the same index in the same cycle: data is written and pend ends at 1, because the reserve wins (a new load has been issued).
- Reserve of an already pending register: no change to pend or PEND_COUNT.
- Read: REGOUT[i] = regArr[READREG[i]], combinational. Any number of ports may read the same index.
- BUSY[i] = pend[READREG[i]], combinational. STALL is combinational from BUSY and READEN.
- PEND_COUNT is a registered counter kept equal to popcount(pend):
  - +1 on an effective set (0->1)
  - -1 on an effective clear (1->0)
  - unchanged when both or neither occur
  - Never wraps; maximum value is DEPTH.
- Write to a non-pending register: legal, no scoreboard effect.

## Timing
- Write latency: one edge; data is visible on REGOUT the cycle after the edge.
- Read latency: zero cycles; there are no #delays in RTL.
- Reset at an edge with RESET=1:
  - all regArr cleared to 0, pend cleared to 0, PEND_COUNT cleared to 0
  - WRITEENABLE and RESERVE are ignored in that cycle
  - Reset mid-operation discards all outstanding reservations.
- Output values after reset: REGOUT=0, BUSY=0, STALL=0, PEND_COUNT=0.
- Before the first reset, state is X. No requirement applies.

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding is enabled. When WRITEENABLE=1 and WRITEREG==READREG[i] in the same cycle:
  - REGOUT[i] = WRITEDATA
  - BUSY[i] = 0, unless RESERVE=1 with RESERVEREG==WRITEREG in that cycle
- REG_FILE_BYPASS_EN undefined: REGOUT and BUSY reflect stored state only. A consumer sees the new value one cycle after writeback.

## Structure
- Shared package (reg_file_pkg) holds:
  - default DATA_W, ADDR_W and NUM_RD constants
  - a helper function for port slice offsets
- One sub-module, reg_scoreboard, holds pend, PEND_COUNT, BUSY and the set/clear priority. The top level holds the array, read muxes and the bypass.

## Test plan
- Reset with READREG0=0 and READREG1=4 -> REGOUT both 0, BUSY=0, PEND_COUNT=0.
- Write 95 to r2 (WRITEENABLE for one edge), then read r2 on port 0:
  - without bypass: REGOUT0=95 in the cycle after the edge
  - with REG_FILE_BYPASS_EN: REGOUT0=95 already in the write cycle
- RESERVE r1, then READREG0=1 with READEN0=1 -> BUSY0=1, STALL=1, PEND_COUNT=1. Write 28 to r1 -> next cycle REGOUT0=28, STALL=0, PEND_COUNT=0.
- In one cycle, RESERVE r4 and write 6 to r4 -> r4 holds 6, BUSY=1 on any port reading r4, PEND_COUNT=1. Re-RESERVE r4 -> PEND_COUNT stays 1.
- RESERVE each of r0..r7 on successive edges -> PEND_COUNT=8 with no wrap. Assert RESET with WRITEENABLE=1 (r7, 50) -> all cleared, r7 reads 0.
- NUM_RD=4 and DATA_W=16, all four ports reading r7 after a write of 16'hBEEF -> every REGOUT slice equals 16'hBEEF. BUSY is only set on ports whose READREG is pending.
